// File: rtl/bc_io_pkg.sv
// -----------------------------------------------------------------------------
// bc_io_pkg
// Shared definitions for the basic-computer character I/O port:
//   DATA_W_DEF    default byte width of INPR/OUTR and both streams
//   IN_DEPTH_DEF  default input buffer depth (bytes)
//   out_state_e   output-side state (IDLE: port can take a byte, BUSY: byte
//                 pending for the external sink)
//   cnt_w()       width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package bc_io_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned IN_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } out_state_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bc_io_fifo.sv
// -----------------------------------------------------------------------------
// bc_io_fifo
// Parameterised synchronous FIFO used as the input byte buffer.
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata write request / data; ignored when full
//   pop         read request; ignored when empty
//   head        oldest entry, 0 when empty (registered state only)
//   empty, full occupancy flags decoded from the registered counter
//   count       occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
// Push and pop in the same cycle both take effect; occupancy is unchanged.
// -----------------------------------------------------------------------------
module bc_io_fifo
  import bc_io_pkg::*;
#(
  parameter int unsigned W     = DATA_W_DEF,
  parameter int unsigned DEPTH = IN_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic                       full,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Protect the storage even if a caller forgets to qualify its requests.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bc_io_port.sv
// -----------------------------------------------------------------------------
// bc_io_port
// Character I/O port between external byte streams and the basic computer's
// INPR/FGI and OUTR/FGO registers.
//
// Build option: IO_IN_FIFO_EN
//   defined   -> input side is an IN_DEPTH-byte FIFO (bc_io_fifo)
//   undefined -> input side is a single holding register, in_ready = !fgi
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   in_valid/in_data/in_ready  producer stream into the port
//   inpr, fgi             byte presented to INPR, input flag
//   inp_ack               one-cycle pulse: INP executed, pop the head byte
//   outr, out_strobe      OUTR value and one-cycle OUT pulse
//   fgo                   output flag: port can take a byte
//   out_valid/out_data/out_ready  sink stream out of the port
//   int_req               fgi | fgo for the interrupt logic
//   ovr_err               sticky: OUT issued while fgo = 0
//
// Handshake rule (both streams): a byte moves on a rising clk edge where
// valid and ready are both high; valid never depends on ready, and ready is
// computed from registered state only, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module bc_io_port
  import bc_io_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned IN_DEPTH = IN_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  input  logic              inp_ack,
  input  logic [DATA_W-1:0] outr,
  input  logic              out_strobe,
  output logic              fgo,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              int_req,
  output logic              ovr_err
);

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
`ifdef IO_IN_FIFO_EN

  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [cnt_w(IN_DEPTH)-1:0]  fifo_count;

  // in_ready comes from the registered occupancy, so a pop in this cycle
  // does not open the FIFO for a push until the next cycle.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = inp_ack && !fifo_empty;
  assign fgi       = (fifo_count != '0);

  bc_io_fifo #(
    .W     (DATA_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .head  (inpr),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`else

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              hold_push;
  logic              hold_pop;

  // Push only when empty and pop only when full, so the two never coincide:
  // a push offered alongside an ack on a full register is simply refused.
  assign in_ready  = !hold_full_q;
  assign hold_push = in_valid && !hold_full_q;
  assign hold_pop  = inp_ack && hold_full_q;
  assign fgi       = hold_full_q;
  assign inpr      = hold_full_q ? hold_q : '0;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (hold_push) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end else if (hold_pop) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // Output side FSM
  // ---------------------------------------------------------------------------
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ovr_q, ovr_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next-state logic. In BUSY an OUT strobe is dropped and flagged even when
  // the sink accepts the pending byte on the same edge; the port then goes
  // IDLE without capturing the dropped byte.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    ovr_d      = ovr_q;
    case (state_q)
      IDLE: begin
        if (out_strobe) begin
          out_data_d = outr;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (out_strobe) begin
          ovr_d = 1'b1;
        end
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    fgo       = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    fgo       = 1'b1;
      BUSY:    out_valid = 1'b1;
      default: fgo       = 1'b0;
    endcase
  end

  assign out_data = out_data_q;
  assign ovr_err  = ovr_q;
  assign int_req  = fgi | fgo;

endmodule
